// File: rtl/regfile_wr_arb_if.sv
// Bundle for the regfile write-port arbiter: WB and multicycle write
// requests, decode read addresses, hazard/stall flags and the regfile write port.
interface regfile_wr_arb_if #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 5
);
    logic              a_valid;
    logic [AWIDTH-1:0] a_addr;
    logic [DWIDTH-1:0] a_data;
    logic              b_valid;
    logic              b_ready;
    logic [AWIDTH-1:0] b_addr;
    logic [DWIDTH-1:0] b_data;
    logic [AWIDTH-1:0] rd_addr1;
    logic [AWIDTH-1:0] rd_addr2;
    logic              hz_stall;
    logic              stall_req;
    logic              r_wr_en;
    logic [AWIDTH-1:0] r_addr_in;
    logic [DWIDTH-1:0] r_data_in;

    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data, rd_addr1, rd_addr2,
        input  b_ready, hz_stall, stall_req, r_wr_en, r_addr_in, r_data_in
    );

    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data, rd_addr1, rd_addr2,
        output b_ready, hz_stall, stall_req, r_wr_en, r_addr_in, r_data_in
    );
endinterface

// File: rtl/regfile_wr_arb.sv
// Shares the single regfile write port between WB (A, always wins) and a
// buffered multicycle unit (B), with WAW kill, starvation stall and read-hazard flag.
module regfile_wr_arb #(
    parameter int DWIDTH     = 32,
    parameter int AWIDTH     = 5,
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input logic             r_clk,
    input logic             r_rst,
    regfile_wr_arb_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [AWIDTH-1:0] r_buf_addr [DEPTH];
    logic [DWIDTH-1:0] r_buf_data [DEPTH];
    logic [DEPTH-1:0]  r_vld;
    logic [DEPTH-1:0]  r_kill;
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    logic [SW-1:0]     r_starve;
    logic              r_wen;
    logic [AWIDTH-1:0] r_waddr;
    logic [DWIDTH-1:0] r_wdata;

    logic w_b_ready;
    logic w_push;
    logic w_pop;
    logic w_a_live;
    logic w_live;
    logic w_push_kill;
    logic w_hz;

    assign w_b_ready   = (r_count < CW'(DEPTH)) && !r_rst;
    assign w_push      = bus.b_valid && w_b_ready;
    assign w_pop       = !bus.a_valid && (r_count != '0);
    assign w_a_live    = bus.a_valid && (bus.a_addr != '0);
    assign w_live      = |(r_vld & ~r_kill);
    // $zero writes and B writes overtaken by a same-edge A write enter already killed
    assign w_push_kill = (bus.b_addr == '0) || (w_a_live && (bus.b_addr == bus.a_addr));

    always_ff @(posedge r_clk) begin
        if (w_push) begin
            r_buf_addr[r_wptr] <= bus.b_addr;
            r_buf_data[r_wptr] <= bus.b_data;
        end
    end

    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            r_vld    <= '0;
            r_kill   <= '0;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_starve <= '0;
            r_wen    <= 1'b0;
            r_waddr  <= '0;
            r_wdata  <= '0;
        end else begin
            if (w_a_live) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (r_vld[PW'(i)] && (r_buf_addr[PW'(i)] == bus.a_addr)) begin
                        r_kill[PW'(i)] <= 1'b1;
                    end
                end
            end
            if (w_pop) begin
                r_vld[r_rptr] <= 1'b0;
                r_rptr        <= r_rptr + 1'b1;
            end
            if (w_push) begin
                r_vld[r_wptr]  <= 1'b1;
                r_kill[r_wptr] <= w_push_kill;
                r_wptr         <= r_wptr + 1'b1;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);

            if (bus.a_valid) begin
                r_wen   <= (bus.a_addr != '0);
                r_waddr <= bus.a_addr;
                r_wdata <= bus.a_data;
            end else if (w_pop) begin
                r_wen   <= !r_kill[r_rptr];
                r_waddr <= r_buf_addr[r_rptr];
                r_wdata <= r_buf_data[r_rptr];
            end else begin
                r_wen <= 1'b0;
            end

            if (bus.a_valid && w_live) begin
                if (r_starve < SW'(STARVE_MAX)) begin
                    r_starve <= r_starve + 1'b1;
                end
            end else if (w_pop || (r_count == '0)) begin
                r_starve <= '0;
            end
        end
    end

    // A pending write (buffered or on the port this cycle) makes the regfile read stale
    always_comb begin
        w_hz = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (r_vld[PW'(i)] && !r_kill[PW'(i)]) begin
                if (((bus.rd_addr1 != '0) && (bus.rd_addr1 == r_buf_addr[PW'(i)])) ||
                    ((bus.rd_addr2 != '0) && (bus.rd_addr2 == r_buf_addr[PW'(i)]))) begin
                    w_hz = 1'b1;
                end
            end
        end
        if (r_wen && (((bus.rd_addr1 != '0) && (bus.rd_addr1 == r_waddr)) ||
                      ((bus.rd_addr2 != '0) && (bus.rd_addr2 == r_waddr)))) begin
            w_hz = 1'b1;
        end
    end

    assign bus.b_ready   = w_b_ready;
    assign bus.hz_stall  = w_hz && !r_rst;
    assign bus.stall_req = (r_starve >= SW'(STARVE_MAX)) && !r_rst;
    assign bus.r_wr_en   = r_wen;
    assign bus.r_addr_in = r_waddr;
    assign bus.r_data_in = r_wdata;
endmodule
